issue_scoreboard: RTL
=====================

Name: issue_scoreboard

Overview:
- Parametrised register scoreboard and issue gate between Decode and the execute units of the core pipeline.
- Successor to the fixed 5-stage hazard handling. It tracks pending destination registers across N functional units with fixed or variable latency, covering the integer ALU, mul/div, atomics and FP pipes.
- Generates RAW, WAW and structural stalls, and releases entries on countdown expiry or on writeback.

Parameters:
- NUM_REGS, 32, architectural registers tracked; index 0 is hardwired zero.
- REG_AW, 5, register index width; must equal clog2(NUM_REGS).
- NUM_SRC, 3, source operands per instruction (3 covers FMA rs3).
- NUM_FU, 4, functional units.
- LAT_W, 4, latency field width; maximum fixed latency is 2^LAT_W-1.
- FU_VAR_MASK, 4'b1100, bit f=1 means FU f is variable-latency and non-pipelined (div, fdiv).

Ports:
- clk  in  1  core clock.
- rstn  in  1  reset, synchronous, active-high (rstn=1 resets).
- issue_valid  in  1  Decode presents an instruction.
- issue_ready  out  1  scoreboard accepts it; accept = issue_valid & issue_ready.
- issue_rs  in  NUM_SRC*REG_AW  source register indices, packed, src0 in the LSBs.
- issue_rs_used  in  NUM_SRC  per-source valid.
- issue_rd  in  REG_AW  destination register.
- issue_rd_we  in  1  instruction writes rd.
- issue_fu  in  clog2(NUM_FU)  target FU.
- issue_lat  in  LAT_W  fixed latency in cycles. Must be 0 for FUs with a FU_VAR_MASK bit set and nonzero for all others.
- wb_valid  in  NUM_FU  FU f completes its result this cycle.
- wb_rd  in  NUM_FU*REG_AW  destination of each completing result.
- flush  in  1  pipeline flush; all in-flight results are discarded.
- busy_vec  out  NUM_REGS  registered pending-write bit per register.
- stall_raw  out  1  combinational; a used source is pending.
- stall_waw  out  1  combinational; rd is pending.
- stall_struct  out  1  combinational; the target variable FU is occupied.
- inflight_cnt  out  clog2(NUM_REGS+1)  registered popcount of busy_vec.

Behaviour:
- Per-register entry: busy, owner fu, cnt[LAT_W].
- Per-FU state: fu_busy, only for FUs with a FU_VAR_MASK bit set.
- Reset (rstn=1 at a clk edge): all busy=0, cnt=0, fu_busy=0. Outputs: busy_vec=0, inflight_cnt=0, issue_ready=0 during the reset cycle. Reset mid-operation discards everything; wb_valid arriving afterwards is ignored.
- Release this cycle (rel[r]) is true in either case:
  - busy & cnt==1 (fixed latency);
  - busy & cnt==0 & wb_valid[owner] & wb_rd[owner]==r (variable latency).
- Effective pending: pend[r] = busy[r] & ~rel[r]. This is a same-cycle release bypass; pend[0] is always 0.
- stall_raw = OR over used sources of pend[rs].
- stall_waw = issue_rd_we & pend[rd].
- stall_struct = FU_VAR_MASK[fu] & fu_busy[fu] & ~wb_valid[fu].
- issue_ready = ~rstn & ~flush & ~stall_raw & ~stall_waw & ~stall_struct. It must not depend on issue_valid.
- Accept with rd_we and rd!=0: next cycle busy[rd]=1, owner=fu, cnt=issue_lat. Accept with rd=0 or rd_we=0 sets no entry.
- Accept to a variable FU sets fu_busy[fu], even when rd_we=0. fu_busy clears on wb_valid[fu]. If a same-FU accept occurs in the same cycle, set wins.
- Fixed entries: cnt decrements every cycle while busy. cnt==1 clears busy next cycle. Latency L therefore gives busy for exactly L cycles, and a dependant can issue in the cycle the Lth busy cycle ends (bypass).
- Simultaneous release and new set on the same register: set wins; the entry holds the new owner and cnt.
- wb_valid whose wb_rd does not match a busy entry owned by that FU is ignored; no error is raised.
- flush: issue_ready=0 that cycle, all busy and fu_busy clear next cycle, inflight_cnt=0 next cycle. FUs receive flush separately and abort.
- stall_* are reported even when issue_valid=0. Decode uses them for performance counters.

Decomposition:
- Package sb_pkg holds the REG_AW/LAT_W defaults, the FU index enum (FU_ALU, FU_MUL, FU_DIV, FU_FDIV) and the sb_entry_t struct {busy, owner, cnt}.
- One sub-module, sb_entry, holds a single register's entry with its set, release and flush logic. It is instantiated NUM_REGS-1 times; index 0 is a tie-off.
- Top-level logic contains the hazard reduction, the fu_busy array and the popcount.

Test Plan:
- Reset, then idle: busy_vec=0, inflight_cnt=0, issue_ready=1 with issue_valid=0.
- Issue x5 to FU_MUL with lat=3, then an instruction with rs1=x5 every cycle: stall_raw=1 for 2 cycles and accept in the 3rd cycle via bypass; busy_vec[5] is high for exactly 3 cycles.
- Issue x7 to FU_DIV (lat=0), then a second DIV: stall_struct=1 until wb_valid[2] with wb_rd=7. In that cycle the second DIV is accepted, fu_busy stays 1, and busy[7] shows the new owner.
- Issue x9 to ALU lat=1 and x9 to MUL lat=4 back-to-back: the second issue gets WAW bypass at release and set wins, so busy[9] is held for 4 more cycles with owner MUL.
- Issue to rd=x0 with rd_we=1: no busy bit is set, and a following rs1=x0 never stalls.
- Three entries pending, then flush: issue_ready=0 in the flush cycle, busy_vec=0 and inflight_cnt=0 next cycle. A late wb_valid[DIV] for a flushed rd is ignored. Asserting rstn mid-countdown gives the same result.

Source files
------------

// File: rtl/issue_scoreboard_pkg.sv
// Shared types and default sizing for the register scoreboard / issue gate.
// Entry field widths here must match the LAT_W / NUM_FU the top is built with.
package sb_pkg;

    localparam int NUM_REGS_D = 32;
    localparam int REG_AW_D   = 5;
    localparam int NUM_SRC_D  = 3;
    localparam int NUM_FU_D   = 4;
    localparam int LAT_W_D    = 4;
    localparam int FU_AW_D    = $clog2(NUM_FU_D);
    localparam logic [NUM_FU_D-1:0] FU_VAR_MASK_D = 4'b1100;

    typedef enum logic [FU_AW_D-1:0] {
        FU_ALU  = 2'd0,
        FU_MUL  = 2'd1,
        FU_DIV  = 2'd2,
        FU_FDIV = 2'd3
    } fu_e;

    typedef struct packed {
        logic               busy;
        fu_e                owner;
        logic [LAT_W_D-1:0] cnt;
    } sb_entry_t;

endpackage

// File: rtl/issue_scoreboard_if.sv
// Decode-side issue handshake, FU writeback and hazard status bundle.
interface issue_scoreboard_if
    import sb_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_D,
    parameter int REG_AW   = REG_AW_D,
    parameter int NUM_SRC  = NUM_SRC_D,
    parameter int NUM_FU   = NUM_FU_D,
    parameter int LAT_W    = LAT_W_D
);
    localparam int FU_AW = $clog2(NUM_FU);
    localparam int CNT_W = $clog2(NUM_REGS + 1);

    logic                      issue_valid;
    logic                      issue_ready;
    logic [NUM_SRC*REG_AW-1:0] issue_rs;
    logic [NUM_SRC-1:0]        issue_rs_used;
    logic [REG_AW-1:0]         issue_rd;
    logic                      issue_rd_we;
    logic [FU_AW-1:0]          issue_fu;
    logic [LAT_W-1:0]          issue_lat;
    logic [NUM_FU-1:0]         wb_valid;
    logic [NUM_FU*REG_AW-1:0]  wb_rd;
    logic                      flush;
    logic [NUM_REGS-1:0]       busy_vec;
    logic                      stall_raw;
    logic                      stall_waw;
    logic                      stall_struct;
    logic [CNT_W-1:0]          inflight_cnt;

    modport master (
        output issue_valid, issue_rs, issue_rs_used, issue_rd, issue_rd_we,
               issue_fu, issue_lat, wb_valid, wb_rd, flush,
        input  issue_ready, busy_vec, stall_raw, stall_waw, stall_struct,
               inflight_cnt
    );

    modport slave (
        input  issue_valid, issue_rs, issue_rs_used, issue_rd, issue_rd_we,
               issue_fu, issue_lat, wb_valid, wb_rd, flush,
        output issue_ready, busy_vec, stall_raw, stall_waw, stall_struct,
               inflight_cnt
    );

endinterface

// File: rtl/issue_scoreboard_entry.sv
// One architectural register's pending-write entry: set on issue, release on
// fixed-latency countdown or on a matching writeback from its owner FU.
module sb_entry
    import sb_pkg::*;
#(
    parameter int REG_IDX = 1,
    parameter int REG_AW  = REG_AW_D,
    parameter int NUM_FU  = NUM_FU_D,
    parameter int LAT_W   = LAT_W_D
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     i_flush,
    input  logic                     i_set,
    input  fu_e                      i_owner,
    input  logic [LAT_W-1:0]         i_lat,
    input  logic [NUM_FU-1:0]        i_wb_valid,
    input  logic [NUM_FU*REG_AW-1:0] i_wb_rd,
    output logic                     o_busy,
    output logic                     o_pend
);

    sb_entry_t r_ent;
    logic      w_wb_hit;
    logic      w_rel;

    always_comb begin
        w_wb_hit = 1'b0;
        for (int f = 0; f < NUM_FU; f++) begin
            if (int'(r_ent.owner) == f && i_wb_valid[f] &&
                i_wb_rd[f*REG_AW +: REG_AW] == REG_AW'(REG_IDX))
                w_wb_hit = 1'b1;
        end
    end

    // cnt==0 marks a variable-latency entry that only a writeback can release.
    assign w_rel  = r_ent.busy & ((r_ent.cnt == LAT_W'(1)) |
                                  ((r_ent.cnt == '0) & w_wb_hit));
    assign o_pend = r_ent.busy & ~w_rel;
    assign o_busy = r_ent.busy;

    always_ff @(posedge clk) begin
        if (rstn || i_flush) begin
            r_ent <= '0;
        end else if (i_set) begin
            r_ent.busy  <= 1'b1;
            r_ent.owner <= i_owner;
            r_ent.cnt   <= i_lat;
        end else if (w_rel) begin
            r_ent.busy <= 1'b0;
            r_ent.cnt  <= '0;
        end else if (r_ent.busy && r_ent.cnt != '0) begin
            r_ent.cnt <= r_ent.cnt - 1'b1;
        end
    end

endmodule

// File: rtl/issue_scoreboard.sv
// Register scoreboard and issue gate between Decode and the execute units:
// RAW/WAW/structural hazard detection with same-cycle release bypass.
module issue_scoreboard
    import sb_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_D,
    parameter int REG_AW   = REG_AW_D,
    parameter int NUM_SRC  = NUM_SRC_D,
    parameter int NUM_FU   = NUM_FU_D,
    parameter int LAT_W    = LAT_W_D,
    parameter logic [NUM_FU-1:0] FU_VAR_MASK = FU_VAR_MASK_D
) (
    input logic               clk,
    input logic               rstn,
    issue_scoreboard_if.slave sb
);

    localparam int FU_AW = $clog2(NUM_FU);
    localparam int CNT_W = $clog2(NUM_REGS + 1);

    logic [NUM_REGS-1:0] w_busy;
    logic [NUM_REGS-1:0] w_pend;
    logic [NUM_REGS-1:0] w_set;
    logic [NUM_REGS-1:0] w_busy_nxt;
    logic                w_raw;
    logic                w_waw;
    logic                w_struct;
    logic                w_ready;
    logic                w_accept;
    logic [NUM_FU-1:0]   r_fu_busy;
    logic [CNT_W-1:0]    r_inflight;

    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_REGS-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_REGS; i++)
            c = c + CNT_W'(v[i]);
        return c;
    endfunction

    // x0 is hardwired zero: never busy, never pending.
    assign w_busy[0] = 1'b0;
    assign w_pend[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_ent
        sb_entry #(
            .REG_IDX (r),
            .REG_AW  (REG_AW),
            .NUM_FU  (NUM_FU),
            .LAT_W   (LAT_W)
        ) u_ent (
            .clk        (clk),
            .rstn       (rstn),
            .i_flush    (sb.flush),
            .i_set      (w_set[r]),
            .i_owner    (fu_e'(sb.issue_fu)),
            .i_lat      (sb.issue_lat),
            .i_wb_valid (sb.wb_valid),
            .i_wb_rd    (sb.wb_rd),
            .o_busy     (w_busy[r]),
            .o_pend     (w_pend[r])
        );
    end

    always_comb begin
        w_raw = 1'b0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (sb.issue_rs_used[s] && w_pend[sb.issue_rs[s*REG_AW +: REG_AW]])
                w_raw = 1'b1;
        end
    end

    assign w_waw    = sb.issue_rd_we & w_pend[sb.issue_rd];
    assign w_struct = FU_VAR_MASK[sb.issue_fu] & r_fu_busy[sb.issue_fu] &
                      ~sb.wb_valid[sb.issue_fu];
    assign w_ready  = ~rstn & ~sb.flush & ~w_raw & ~w_waw & ~w_struct;
    assign w_accept = sb.issue_valid & w_ready;

    always_comb begin
        w_set = '0;
        for (int r = 1; r < NUM_REGS; r++)
            w_set[r] = w_accept & sb.issue_rd_we & (sb.issue_rd == REG_AW'(r));
    end

    // Mirrors each entry's next busy state so the count lines up with busy_vec.
    assign w_busy_nxt = w_set | w_pend;

    always_ff @(posedge clk) begin
        if (rstn || sb.flush) begin
            r_fu_busy  <= '0;
            r_inflight <= '0;
        end else begin
            r_inflight <= popcount(w_busy_nxt);
            for (int f = 0; f < NUM_FU; f++) begin
                if (FU_VAR_MASK[f]) begin
                    if (w_accept && sb.issue_fu == FU_AW'(f))
                        r_fu_busy[f] <= 1'b1;
                    else if (sb.wb_valid[f])
                        r_fu_busy[f] <= 1'b0;
                end
            end
        end
    end

    assign sb.issue_ready  = w_ready;
    assign sb.busy_vec     = w_busy;
    assign sb.stall_raw    = w_raw;
    assign sb.stall_waw    = w_waw;
    assign sb.stall_struct = w_struct;
    assign sb.inflight_cnt = r_inflight;

endmodule
